// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Package : stopwatch_pkg
// Brief   : Time-field widths, limits and time-word pack/unpack helpers.
// Rev     : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int TIME_W = 24;

    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } sw_time_t;

    function automatic logic [TIME_W-1:0] pack_time(input sw_time_t t);
        return {t.hour, t.min, t.sec, t.msec};
    endfunction

    function automatic sw_time_t unpack_time(input logic [TIME_W-1:0] w);
        return sw_time_t'(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lap_fifo.sv
`default_nettype none
// ============================================================================
// Module : lap_fifo
// Brief  : Show-ahead synchronous FIFO for lap times, with count and sticky
//          overflow flag.
// Rev    : 1.0 - initial release
// ============================================================================
module lap_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && !w_do_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_valid    = ~w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/stopwatch_timer_dp.sv
`default_nettype none
// ============================================================================
// Module : stopwatch_timer_dp
// Brief  : Stopwatch / countdown-timer datapath with prescaler, preset load,
//          expiry pulse and lap-capture buffer.
// Rev    : 1.0 - initial release
// ============================================================================
module stopwatch_timer_dp
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clear,
    input  logic                          i_run,
    input  logic                          i_mode,
    input  logic                          i_load,
    input  logic [HOUR_W-1:0]             i_load_hour,
    input  logic [MIN_W-1:0]              i_load_min,
    input  logic [SEC_W-1:0]              i_load_sec,
    input  logic                          i_lap,
    input  logic                          i_lap_rd,
    output logic [MSEC_W-1:0]             o_msec,
    output logic [SEC_W-1:0]              o_sec,
    output logic [MIN_W-1:0]              o_min,
    output logic [HOUR_W-1:0]             o_hour,
    output logic                          o_running,
    output logic                          o_expired,
    output logic                          o_lap_valid,
    output logic [TIME_W-1:0]             o_lap_data,
    output logic [$clog2(LAP_DEPTH):0]    o_lap_count,
    output logic                          o_lap_overflow
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] c_DIV_LAST = PW'(DIV - 1);

    sw_time_t      r_time;
    logic [PW-1:0] r_presc;
    logic          r_expired;

    sw_time_t w_next;
    sw_time_t w_load_time;
    logic     w_time_zero;
    logic     w_running;
    logic     w_tick;

    assign w_time_zero = (r_time == '0);
    assign w_running   = i_run & ~(i_mode & w_time_zero);
    assign w_tick      = w_running & (r_presc == c_DIV_LAST);

    assign w_load_time.hour = (i_load_hour > HOUR_MAX) ? HOUR_MAX : i_load_hour;
    assign w_load_time.min  = (i_load_min  > MIN_MAX)  ? MIN_MAX  : i_load_min;
    assign w_load_time.sec  = (i_load_sec  > SEC_MAX)  ? SEC_MAX  : i_load_sec;
    assign w_load_time.msec = '0;

    // Full carry/borrow chain resolves in one cycle so all fields move together.
    always_comb begin
        w_next = r_time;
        if (!i_mode) begin
            if (r_time.msec == MSEC_MAX) begin
                w_next.msec = '0;
                if (r_time.sec == SEC_MAX) begin
                    w_next.sec = '0;
                    if (r_time.min == MIN_MAX) begin
                        w_next.min  = '0;
                        w_next.hour = (r_time.hour == HOUR_MAX) ? '0 : r_time.hour + 5'd1;
                    end else begin
                        w_next.min = r_time.min + 6'd1;
                    end
                end else begin
                    w_next.sec = r_time.sec + 6'd1;
                end
            end else begin
                w_next.msec = r_time.msec + 7'd1;
            end
        end else begin
            if (r_time.msec == '0) begin
                w_next.msec = MSEC_MAX;
                if (r_time.sec == '0) begin
                    w_next.sec = SEC_MAX;
                    if (r_time.min == '0) begin
                        w_next.min  = MIN_MAX;
                        w_next.hour = (r_time.hour == '0) ? HOUR_MAX : r_time.hour - 5'd1;
                    end else begin
                        w_next.min = r_time.min - 6'd1;
                    end
                end else begin
                    w_next.sec = r_time.sec - 6'd1;
                end
            end else begin
                w_next.msec = r_time.msec - 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_time    <= '0;
            r_presc   <= '0;
            r_expired <= 1'b0;
        end else if (i_clear) begin
            r_time    <= '0;
            r_presc   <= '0;
            r_expired <= 1'b0;
        end else if (i_load) begin
            r_time    <= w_load_time;
            r_presc   <= '0;
            r_expired <= 1'b0;
        end else begin
            // A stopped prescaler keeps its phase so a restart resumes mid-period.
            if (w_running) r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick)    r_time  <= w_next;
            r_expired <= w_tick & i_mode & (w_next == '0);
        end
    end

    lap_fifo #(
        .WIDTH (TIME_W),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (i_clear),
        .i_push     (i_lap),
        .i_pop      (i_lap_rd),
        .i_data     (pack_time(r_time)),
        .o_data     (o_lap_data),
        .o_valid    (o_lap_valid),
        .o_count    (o_lap_count),
        .o_overflow (o_lap_overflow)
    );

    assign o_msec    = r_time.msec;
    assign o_sec     = r_time.sec;
    assign o_min     = r_time.min;
    assign o_hour    = r_time.hour;
    assign o_running = w_running;
    assign o_expired = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_timer_dp.sv
`default_nettype none
// ============================================================================
// Module : tb_stopwatch_timer_dp
// Brief  : Directed and randomized bench against a centisecond-count model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_timer_dp;

    localparam int CLK_FREQ  = 1000;
    localparam int TICK_HZ   = 100;
    localparam int LAP_DEPTH = 4;
    localparam int DIV       = CLK_FREQ / TICK_HZ;
    localparam int DAY       = 24 * 3600 * 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_clear, i_run, i_mode, i_load, i_lap, i_lap_rd;
    logic [4:0]  i_load_hour;
    logic [5:0]  i_load_min, i_load_sec;
    logic [6:0]  o_msec;
    logic [5:0]  o_sec, o_min;
    logic [4:0]  o_hour;
    logic        o_running, o_expired, o_lap_valid, o_lap_overflow;
    logic [23:0] o_lap_data;
    logic [2:0]  o_lap_count;

    stopwatch_timer_dp #(
        .CLK_FREQ  (CLK_FREQ),
        .TICK_HZ   (TICK_HZ),
        .LAP_DEPTH (LAP_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (i_clear),
        .i_run          (i_run),
        .i_mode         (i_mode),
        .i_load         (i_load),
        .i_load_hour    (i_load_hour),
        .i_load_min     (i_load_min),
        .i_load_sec     (i_load_sec),
        .i_lap          (i_lap),
        .i_lap_rd       (i_lap_rd),
        .o_msec         (o_msec),
        .o_sec          (o_sec),
        .o_min          (o_min),
        .o_hour         (o_hour),
        .o_running      (o_running),
        .o_expired      (o_expired),
        .o_lap_valid    (o_lap_valid),
        .o_lap_data     (o_lap_data),
        .o_lap_count    (o_lap_count),
        .o_lap_overflow (o_lap_overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: time as total centiseconds, laps as a queue.
    int          m_t;
    int          m_pc;
    bit          m_exp;
    bit          m_ovf;
    logic [23:0] m_q[$];

    int          n_exp;
    logic [23:0] caps [5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] to_word(input int t);
        int h, m, s, cs;
        h  = t / 360000;
        m  = (t / 6000) % 60;
        s  = (t / 100) % 60;
        cs = t % 100;
        return {5'(h), 6'(m), 6'(s), 7'(cs)};
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_t = 0; m_pc = 0; m_exp = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic compare_all();
        chk("time", {8'h0, o_hour, o_min, o_sec, o_msec}, {8'h0, to_word(m_t)});
        chk("running", o_running, i_run && !(i_mode && m_t == 0));
        chk("expired", o_expired, m_exp);
        chk("lap_valid", o_lap_valid, m_q.size() > 0);
        chk("lap_count", o_lap_count, m_q.size());
        chk("lap_ovf", o_lap_overflow, m_ovf);
        chk("lap_data", o_lap_data, (m_q.size() > 0) ? m_q[0] : 24'h0);
    endtask

    task automatic step();
        bit r, tick, do_pop;
        int nt;
        r    = i_run && !(i_mode && m_t == 0);
        tick = r && (m_pc == DIV - 1);
        if (i_clear) begin
            model_reset();
        end else begin
            do_pop = i_lap_rd && (m_q.size() > 0);
            if (i_lap && m_q.size() == LAP_DEPTH && !do_pop) m_ovf = 1;
            if (do_pop) void'(m_q.pop_front());
            if (i_lap && (m_q.size() < LAP_DEPTH)) m_q.push_back(to_word(m_t));
            if (i_load) begin
                m_t = sat(int'(i_load_hour), 23) * 360000 + sat(int'(i_load_min), 59) * 6000
                    + sat(int'(i_load_sec), 59) * 100;
                m_pc  = 0;
                m_exp = 0;
            end else begin
                if (r) m_pc = tick ? 0 : m_pc + 1;
                if (tick) begin
                    nt    = i_mode ? m_t - 1 : (m_t + 1) % DAY;
                    m_exp = i_mode && (nt == 0);
                    m_t   = nt;
                end else begin
                    m_exp = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        compare_all();
        if (o_expired) n_exp++;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        i_load = 1; i_load_hour = 5'(h); i_load_min = 6'(m); i_load_sec = 6'(s);
        step();
        i_load = 0;
    endtask

    initial begin
        rst = 1; i_clear = 0; i_run = 0; i_mode = 0; i_load = 0; i_lap = 0; i_lap_rd = 0;
        i_load_hour = 0; i_load_min = 0; i_load_sec = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 0;

        // Up count, then pause/resume keeps prescaler phase
        i_run = 1;
        repeat (1000) step();
        chk("up_1s", {o_sec, o_msec}, {6'd1, 7'd0});
        repeat (5) step();
        i_run = 0;
        repeat (50) step();
        i_run = 1;
        repeat (4) step();
        chk("resume_early", o_msec, 7'd0);
        step();
        chk("resume_tick", o_msec, 7'd1);

        // Wrap at end of day
        n_exp = 0;
        do_load(23, 59, 59);
        repeat (1000) step();
        chk("wrap_time", {o_hour, o_min, o_sec, o_msec}, 24'h0);
        chk("wrap_no_exp", n_exp, 0);

        // Countdown to zero and hold
        i_mode = 1;
        do_load(0, 0, 1);
        n_exp = 0;
        repeat (1000) step();
        chk("cd_zero", {o_hour, o_min, o_sec, o_msec}, 24'h0);
        repeat (100) step();
        chk("cd_one_pulse", n_exp, 1);
        chk("cd_halted", o_running, 1'b0);

        // Back to up mode; load saturates and swallows the coincident tick
        i_mode = 0;
        repeat (DIV - 1) step();
        do_load(30, 63, 60);
        chk("sat_load", {o_hour, o_min, o_sec, o_msec}, {5'd23, 6'd59, 6'd59, 7'd0});

        // Lap buffer: overflow, ordering, empty pop, full push+pop
        for (int i = 0; i < 5; i++) begin
            caps[i] = to_word(m_t);
            i_lap = 1; step(); i_lap = 0;
            repeat (7) step();
        end
        chk("lap_full", o_lap_count, 3'd4);
        chk("lap_ovf_set", o_lap_overflow, 1'b1);
        chk("lap_head", o_lap_data, caps[0]);
        for (int i = 0; i < 4; i++) begin
            chk("lap_order", o_lap_data, caps[i]);
            i_lap_rd = 1; step(); i_lap_rd = 0;
        end
        chk("lap_drained", o_lap_valid, 1'b0);
        i_lap_rd = 1; step(); i_lap_rd = 0;
        chk("lap_pop_empty", o_lap_count, 3'd0);
        repeat (4) begin
            i_lap = 1; step(); i_lap = 0;
            step();
        end
        i_lap = 1; i_lap_rd = 1; step(); i_lap = 0; i_lap_rd = 0;
        chk("lap_pushpop_full", o_lap_count, 3'd4);

        // Clear mid-run with two laps held and overflow still sticky
        do_load(0, 0, 0);
        for (int k = 0; k < 3470; k++) begin
            i_lap_rd = (k < 4);
            i_lap    = (k == 100 || k == 200);
            step();
        end
        i_lap = 0; i_lap_rd = 0;
        chk("pre_clear_time", {o_hour, o_min, o_sec, o_msec}, {5'd0, 6'd0, 6'd3, 7'd47});
        chk("pre_clear_laps", o_lap_count, 3'd2);
        i_clear = 1; step(); i_clear = 0;
        chk("clear_time", {o_hour, o_min, o_sec, o_msec}, 24'h0);
        chk("clear_laps", o_lap_count, 3'd0);
        chk("clear_ovf", o_lap_overflow, 1'b0);
        repeat (DIV - 1) step();
        chk("clear_no_tick", o_msec, 7'd0);
        step();
        chk("clear_tick", o_msec, 7'd1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            i_run    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) i_mode = ~i_mode;
            i_clear  = ($urandom_range(0, 499) == 0);
            i_load   = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 1) == 0) begin
                i_load_hour = 5'($urandom_range(0, 31));
                i_load_min  = 6'($urandom_range(0, 63));
                i_load_sec  = 6'($urandom_range(0, 63));
            end else begin
                i_load_hour = 0; i_load_min = 0;
                i_load_sec  = 6'($urandom_range(0, 2));
            end
            i_lap    = ($urandom_range(0, 15) == 0);
            i_lap_rd = ($urandom_range(0, 15) == 0);
            step();
        end
        i_clear = 0; i_load = 0; i_lap = 0; i_lap_rd = 0;

        // Asynchronous reset between clock edges
        i_mode = 0; i_run = 1;
        do_load(1, 2, 3);
        i_lap = 1; step(); i_lap = 0;
        #2 rst = 1;
        #1;
        chk("async_rst_time", {o_hour, o_min, o_sec, o_msec}, 24'h0);
        chk("async_rst_laps", o_lap_count, 3'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_timer_dp.md
Name: stopwatch_timer_dp

Overview:
Parametrised successor of the stopwatch datapath. It adds an up/down mode: stopwatch or countdown timer with preset load and an expiry pulse. It also adds a lap-capture buffer of configurable depth. The run/stop control is a clock enable rather than a gated clock. The block sits between the stopwatch control FSM (run/clear/lap/mode strobes) and the display/UART formatting logic.

Parameters:
CLK_FREQ, 100_000_000, input clock frequency in Hz
TICK_HZ, 100, base-count rate in Hz; prescaler divide DIV = CLK_FREQ/TICK_HZ (integer, >=2)
LAP_DEPTH, 4, lap buffer entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
clear  in  1  sync clear of prescaler, time, lap buffer, flags
run  in  1  level; 1 = prescaler advances
mode  in  1  0 = count up (stopwatch), 1 = count down (timer)
load  in  1  pulse; preset time from load_* inputs
load_hour  in  5  preset hours
load_min  in  6  preset minutes
load_sec  in  6  preset seconds
lap  in  1  pulse; capture current time into lap buffer
lap_rd  in  1  pulse; pop head entry of lap buffer
msec  out  7  centiseconds 0..99
sec  out  6  0..59
min  out  6  0..59
hour  out  5  0..23
running  out  1  prescaler currently enabled
expired  out  1  one-cycle pulse when countdown reaches zero
lap_valid  out  1  lap buffer non-empty
lap_data  out  24  head entry {hour,min,sec,msec}, show-ahead
lap_count  out  clog2(LAP_DEPTH)+1  entries held
lap_overflow  out  1  sticky; a lap was dropped while full

Behaviour:
- Reset and clear: all outputs are 0, prescaler is 0, lap buffer is empty.
- Priority, highest first: rst > clear > load > tick. Lap push/pop are independent of this priority.
- running = run & ~(mode & time==0).
- Prescaler:
  - Counts 0..DIV-1 while running and emits a one-cycle tick at DIV-1.
  - It holds its value, not reset, when running=0, so a restart resumes the partial period.
- Count up:
  - On a tick, msec increments; carries ripple through sec/min/hour in the same cycle. All fields are registered together, with no per-stage carry delay.
  - 23:59:59.99 plus one tick wraps to 00:00:00.00 with no flag.
- Count down:
  - On a tick, msec decrements with borrow through all fields in the same cycle.
  - A transition to 00:00:00.00 asserts expired for exactly the cycle after the tick, i.e. while the zero value first appears. Counting then halts at zero.
  - With time==0 in down mode, running=0 and no further expired pulse occurs until the time is nonzero again.
- Load:
  - hour/min/sec take the load values; msec=0.
  - Out-of-range values saturate: hour>23 becomes 23, min/sec>59 become 59.
  - The prescaler resets to 0.
  - Load is allowed in either mode and whether running or not.
  - A tick in the same cycle as load is discarded.
- Mode change: takes effect at the next tick; the time value is unchanged. Switching to up mode from a zero hold resumes counting if run=1.
- Lap capture:
  - On a lap pulse, the pre-update time of that cycle is pushed; a same-cycle tick is not included.
  - Push when full: the entry is dropped and lap_overflow is set.
  - Pop when empty: ignored.
  - Push and pop in the same cycle when full: both are performed and lap_count is unchanged.
  - Push and pop in the same cycle when empty: the push is performed and the pop is ignored.
  - lap_data is valid whenever lap_valid=1 and is undefined otherwise, driven as 0.
- lap_overflow: cleared only by rst or clear.
- clear mid-count: the next cycle shows 00:00:00.00. run is not affected, so counting restarts from zero if run=1.

Decomposition:
- Package stopwatch_pkg holds:
  - field widths: MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5, TIME_W=24
  - field limits: MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23
  - pack/unpack helpers for the 24-bit time word
- One sub-module, lap_fifo: synchronous FIFO, TIME_W wide, LAP_DEPTH deep, with show-ahead read, count, and the overflow flag.

Test Plan:
All cases use CLK_FREQ=1000, TICK_HZ=100, so DIV=10.
- Up count: run=1 from reset for 1000 clk -> msec=0, sec=1. Deassert run after 1005 clk, hold 50 clk, reassert -> next tick arrives 5 clk after reassertion.
- Wrap: load 23:59:59, mode=0, run for 1000 clk -> 00:00:00.00, with no expired pulse at any point.
- Countdown: load 00:00:01, mode=1, run=1 -> after 1000 clk shows 00:00:00.00 and expired is high for exactly 1 cycle; a further 100 clk gives no change, running=0 and no second pulse.
- Load saturation plus precedence: load_hour=30, load_min=63, load_sec=60 asserted on the same cycle as a tick -> 23:59:59.00 and the tick is ignored.
- Lap buffer, LAP_DEPTH=4:
  - Push 5 laps at distinct times -> lap_count=4 and lap_overflow=1; lap_data equals the first captured time.
  - Pop 4 -> entries come out in capture order, then lap_valid=0.
  - Pop when empty -> no change.
  - Simultaneous push and pop when full -> count stays 4.
- Clear mid-run: at 00:00:03.47 with 2 laps stored, pulse clear -> time 0, lap_count=0, lap_overflow=0; counting resumes with the next tick 10 clk later.
